// File: rtl/dmr_pkg.sv
// Shared types and constants for the data-memory responder: FSM states, address regions,
// MMIO offsets and the request address decoder.
package dmr_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned LED_W  = 10;
  localparam int unsigned SEG_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_MMIO = 4'hF;

  localparam logic [7:0] OFF_LED     = 8'h00;
  localparam logic [7:0] OFF_SEG     = 8'h04;
  localparam logic [7:0] OFF_CYCLE   = 8'h08;
  localparam logic [7:0] OFF_CMP     = 8'h0C;
  localparam logic [7:0] OFF_IRQ_CLR = 8'h10;

  typedef enum logic [2:0] {
    TGT_RAM    = 3'd0,
    TGT_LED    = 3'd1,
    TGT_SEG    = 3'd2,
    TGT_CYCLE  = 3'd3,
    TGT_CMP    = 3'd4,
    TGT_IRQCLR = 3'd5,
    TGT_NONE   = 3'd6
  } target_e;

  // Map a request onto its target; offset arrives word-aligned, timer registers only when enabled.
  function automatic target_e dmr_decode(input logic [3:0] region, input logic [7:0] offset,
                                         input logic timer_en);
    target_e tgt;
    tgt = TGT_NONE;
    if (region == REGION_RAM) begin
      tgt = TGT_RAM;
    end else if (region == REGION_MMIO) begin
      case (offset)
        OFF_LED:     tgt = TGT_LED;
        OFF_SEG:     tgt = TGT_SEG;
        OFF_CYCLE:   tgt = TGT_CYCLE;
        OFF_CMP:     tgt = timer_en ? TGT_CMP : TGT_NONE;
        OFF_IRQ_CLR: tgt = timer_en ? TGT_IRQCLR : TGT_NONE;
        default:     tgt = TGT_NONE;
      endcase
    end
    return tgt;
  endfunction

endpackage

// File: rtl/dmr_ram.sv
// Synchronous single-port word RAM; a read during a write returns the old word.
module dmr_ram
  import dmr_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory port: req/ack access to a word RAM and LED/SEG/CYCLE MMIO
// with programmable wait states. Define DMR_TIMER_EN to add the CMP register and sticky irq.
module data_mem_responder
  import dmr_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wren,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [LED_W-1:0]  led,
  output logic [SEG_W-1:0]  seg,
  output logic              irq
);

`ifdef DMR_TIMER_EN
  localparam logic TIMER_EN = 1'b1;
`else
  localparam logic TIMER_EN = 1'b0;
`endif

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_STATES - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                capture_c;

  target_e             req_tgt_c;
  target_e             resp_tgt_c;
  logic                txn_wren_q;
  target_e             txn_tgt_q;
  logic [ADDR_W-1:0]   txn_word_q;
  logic [DATA_W-1:0]   txn_wdata_q;

  logic                ack_q, err_q;
  logic [LED_W-1:0]    led_q;
  logic [SEG_W-1:0]    seg_q;
  logic [DATA_W-1:0]   cycle_q;

  logic                commit_c;
  logic                ram_we_c;
  logic [ADDR_W-1:0]   ram_addr_c;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DATA_W-1:0]   rdata_mux_c;

  logic                unused_addr_c;
  assign unused_addr_c = ^{addr[27:ADDR_W+2], addr[1:0]};

  assign req_tgt_c  = dmr_decode(addr[31:28], {addr[7:2], 2'b00}, TIMER_EN);
  assign resp_tgt_c = capture_c ? req_tgt_c : txn_tgt_q;

  // Next-state logic: IDLE samples req, WAIT counts WAIT_STATES cycles, RESP lasts one cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    capture_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          capture_c  = 1'b1;
          wait_cnt_d = '0;
          state_d    = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ack_q      <= (state_d == ST_RESP);
      err_q      <= (state_d == ST_RESP) && (resp_tgt_c == TGT_NONE);
    end
  end

  // Request fields are frozen here so later input changes cannot disturb the transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_wren_q  <= 1'b0;
      txn_tgt_q   <= TGT_NONE;
      txn_word_q  <= '0;
      txn_wdata_q <= '0;
    end else if (capture_c) begin
      txn_wren_q  <= wren;
      txn_tgt_q   <= req_tgt_c;
      txn_word_q  <= addr[ADDR_W+1:2];
      txn_wdata_q <= wdata;
    end
  end

  // Stores take effect on the edge that leaves RESP, so a reset before then drops them.
  assign commit_c = (state_q == ST_RESP) && txn_wren_q;
  assign ram_we_c = commit_c && (txn_tgt_q == TGT_RAM);

  // In IDLE the RAM reads the live address so a zero-wait load has its word ready in RESP.
  assign ram_addr_c = (state_q == ST_IDLE) ? addr[ADDR_W+1:2] : txn_word_q;

  dmr_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (txn_wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q   <= '0;
      seg_q   <= '0;
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + DATA_W'(1);
      if (commit_c && (txn_tgt_q == TGT_LED)) begin
        led_q <= txn_wdata_q[LED_W-1:0];
      end
      if (commit_c && (txn_tgt_q == TGT_SEG)) begin
        seg_q <= txn_wdata_q[SEG_W-1:0];
      end
    end
  end

`ifdef DMR_TIMER_EN
  logic [DATA_W-1:0] cmp_q;
  logic              irq_q;

  // CMP resets to all-ones so irq does not fire on the first cycle out of reset; set beats clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_q <= '1;
      irq_q <= 1'b0;
    end else begin
      if (commit_c && (txn_tgt_q == TGT_CMP)) begin
        cmp_q <= txn_wdata_q;
      end
      if (cycle_q == cmp_q) begin
        irq_q <= 1'b1;
      end else if (commit_c && (txn_tgt_q == TGT_IRQCLR)) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_mux_c = '0;
    case (txn_tgt_q)
      TGT_RAM:    rdata_mux_c = ram_rdata;
      TGT_LED:    rdata_mux_c = DATA_W'(led_q);
      TGT_SEG:    rdata_mux_c = DATA_W'(seg_q);
      TGT_CYCLE:  rdata_mux_c = cycle_q;
`ifdef DMR_TIMER_EN
      TGT_CMP:    rdata_mux_c = cmp_q;
      TGT_IRQCLR: rdata_mux_c = DATA_W'(irq_q);
`endif
      default:    rdata_mux_c = '0;
    endcase
  end

  // Load data is only presented during the ack cycle of a load; zero otherwise.
  assign rdata = (ack_q && !txn_wren_q) ? rdata_mux_c : '0;
  assign ack   = ack_q;
  assign err   = err_q;
  assign led   = led_q;
  assign seg   = seg_q;

endmodule
